alu181_nibble_seq: RTL and testbench

- Sequencer that runs W-bit operations (W = 4*NIBBLES) on a single external 4-bit 74181-style ALU slice, one nibble per clock, LSB nibble first.
- Between nibbles it feeds the slice's ripple-carry output back into its carry input.
- Accepts one operation through a valid/ready request port and returns result, carry-out, A=B and zero flags through a valid/ready response port.
- Sits between the project's top-level I/O logic and the 74181 datapath.

---
 rtl/alu181_pkg.sv | 14 +
 rtl/alu181_nibble_seq.sv | 115 +++++++++++
 tb/tb_alu181_nibble_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu181_pkg.sv
// alu181_pkg: shared state type, nibble width and 74181 function codes
//    used by the nibble sequencer and anything that drives or models the slice.
package alu181_pkg;
   localparam int NIBBLE_W = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   typedef struct packed {
      logic [3:0] s;
      logic       m;
   } fn_t;
   localparam fn_t FN_ADD = '{s: 4'b1001, m: 1'b0};
   localparam fn_t FN_SUB = '{s: 4'b0110, m: 1'b0};
   localparam fn_t FN_XOR = '{s: 4'b0110, m: 1'b1};
   localparam fn_t FN_AND = '{s: 4'b1011, m: 1'b1};
endpackage

// File: rtl/alu181_nibble_seq.sv
// alu181_nibble_seq: runs a W-bit operation on one external 4-bit 74181 slice,
//    one nibble per clock, LSB nibble first, rippling Cn+4 back into Cn.
//    clk, rst_n           : clock, asynchronous active-low reset
//    i_req_*/o_req_ready  : operation request (A, B, S, M, raw Cn) handshake
//    o_alu_*/i_alu_*      : nibble operands/controls to the slice, F/Cn+4/A=B back
//    o_rsp_*/i_rsp_ready  : result, raw carry-out, A=B and zero flags handshake
//    o_busy               : sequencer is not idle
module alu181_nibble_seq
   import alu181_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int W       = NIBBLE_W * NIBBLES,
   localparam int IW      = $clog2(NIBBLES)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic [W-1:0]        i_req_a,
   input  logic [W-1:0]        i_req_b,
   input  logic [3:0]          i_req_s,
   input  logic                i_req_m,
   input  logic                i_req_cn,
   output logic [NIBBLE_W-1:0] o_alu_a,
   output logic [NIBBLE_W-1:0] o_alu_b,
   output logic [3:0]          o_alu_s,
   output logic                o_alu_m,
   output logic                o_alu_cn,
   input  logic [NIBBLE_W-1:0] i_alu_f,
   input  logic                i_alu_cn4,
   input  logic                i_alu_aeqb,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic [W-1:0]        o_rsp_f,
   output logic                o_rsp_cout,
   output logic                o_rsp_aeqb,
   output logic                o_rsp_zero,
   output logic                o_busy
);
   state_t        r_state;
   logic [IW-1:0] r_idx;
   logic [W-1:0]  r_a, r_b, r_res, r_rsp_f, w_res;
   logic [3:0]    r_s;
   logic          r_m, r_cn, r_aeqb, r_rsp_cout, r_rsp_aeqb, r_rsp_zero;
   logic          w_run, w_last, w_aeqb;
   assign w_run  = r_state == RUN;
   assign w_last = r_idx == IW'(NIBBLES - 1);
   assign w_aeqb = r_aeqb & i_alu_aeqb;
   // Accumulated result with the current slice output merged into its nibble.
   always_comb begin
      w_res = r_res;
      w_res[NIBBLE_W*r_idx +: NIBBLE_W] = i_alu_f;
   end
   // Slice controls come only from registers and read as zero outside RUN.
   assign o_alu_a     = w_run ? r_a[NIBBLE_W-1:0] : '0;
   assign o_alu_b     = w_run ? r_b[NIBBLE_W-1:0] : '0;
   assign o_alu_s     = w_run ? r_s : '0;
   assign o_alu_m     = w_run & r_m;
   assign o_alu_cn    = w_run & r_cn;
   assign o_req_ready = r_state == IDLE;
   assign o_busy      = r_state != IDLE;
   assign o_rsp_valid = r_state == DONE;
   assign o_rsp_f     = r_rsp_f;
   assign o_rsp_cout  = r_rsp_cout;
   assign o_rsp_aeqb  = r_rsp_aeqb;
   assign o_rsp_zero  = r_rsp_zero;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_res      <= '0;
         r_s        <= '0;
         r_m        <= 1'b0;
         r_cn       <= 1'b0;
         r_aeqb     <= 1'b0;
         r_rsp_f    <= '0;
         r_rsp_cout <= 1'b0;
         r_rsp_aeqb <= 1'b0;
         r_rsp_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (i_req_valid) begin
               r_a     <= i_req_a;
               r_b     <= i_req_b;
               r_s     <= i_req_s;
               r_m     <= i_req_m;
               r_cn    <= i_req_cn;
               r_idx   <= '0;
               r_aeqb  <= 1'b1;
               r_state <= RUN;
            end
            RUN: begin
               r_res  <= w_res;
               r_cn   <= i_alu_cn4;
               r_aeqb <= w_aeqb;
               r_a    <= r_a >> NIBBLE_W;
               r_b    <= r_b >> NIBBLE_W;
               // Index parks at zero after the last nibble so it never wraps mid-run.
               r_idx  <= w_last ? '0 : r_idx + IW'(1);
               if (w_last) begin
                  r_rsp_f    <= w_res;
                  r_rsp_cout <= i_alu_cn4;
                  r_rsp_aeqb <= w_aeqb;
                  r_rsp_zero <= w_res == '0;
                  r_state    <= DONE;
               end
            end
            DONE: if (i_rsp_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu181_nibble_seq.sv
// tb_alu181_nibble_seq: directed scoreboard bench driving the sequencer against a 74181 slice model.
module tb_alu181_nibble_seq;
   import alu181_pkg::*;
   localparam int N = 4;
   localparam int W = 4 * N;
   typedef struct {
      logic [W-1:0] f;
      logic         cout;
      logic         aeqb;
      logic         zero;
   } exp_t;
   logic         clk = 1'b0, rst_n = 1'b0;
   logic         req_valid = 1'b0, req_m = 1'b0, req_cn = 1'b0, rsp_ready = 1'b0;
   logic [W-1:0] req_a = '0, req_b = '0;
   logic [3:0]   req_s = '0;
   logic         req_ready, alu_m, alu_cn, alu_cn4, alu_aeqb, rsp_valid;
   logic         rsp_cout, rsp_aeqb, rsp_zero, busy;
   logic [3:0]   alu_a, alu_b, alu_s, alu_f;
   logic [W-1:0] rsp_f;
   int           checks = 0, failures = 0;
   exp_t         q[$];
   logic [3:0]   tr_a[8], tr_b[8], tr_s0;
   logic         tr_cn[8], tr_m0;
   always #5 clk = ~clk;
   alu181_nibble_seq #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_a(req_a), .i_req_b(req_b), .i_req_s(req_s), .i_req_m(req_m), .i_req_cn(req_cn),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_s(alu_s), .o_alu_m(alu_m), .o_alu_cn(alu_cn),
      .i_alu_f(alu_f), .i_alu_cn4(alu_cn4), .i_alu_aeqb(alu_aeqb),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_f(rsp_f), .o_rsp_cout(rsp_cout), .o_rsp_aeqb(rsp_aeqb), .o_rsp_zero(rsp_zero),
      .o_busy(busy)
   );
   // Active-high-data 74181: arithmetic is X + Y + carry, Cn/Cn+4 active-low,
   // Cn+4 independent of M, A=B high when F is all ones.
   function automatic logic [5:0] slice(input logic [3:0] a, b, s, input logic m, cn);
      logic [3:0] x, y, lf;
      logic [4:0] sum;
      case (s)
         4'h0: begin x = a;       y = 4'h0;   end
         4'h1: begin x = a | b;   y = 4'h0;   end
         4'h2: begin x = a | ~b;  y = 4'h0;   end
         4'h3: begin x = 4'h0;    y = 4'hF;   end
         4'h4: begin x = a;       y = a & ~b; end
         4'h5: begin x = a | b;   y = a & ~b; end
         4'h6: begin x = a;       y = ~b;     end
         4'h7: begin x = a & ~b;  y = 4'hF;   end
         4'h8: begin x = a;       y = a & b;  end
         4'h9: begin x = a;       y = b;      end
         4'hA: begin x = a | ~b;  y = a & b;  end
         4'hB: begin x = a & b;   y = 4'hF;   end
         4'hC: begin x = a;       y = a;      end
         4'hD: begin x = a | b;   y = a;      end
         4'hE: begin x = a | ~b;  y = a;      end
         default: begin x = a;    y = 4'hF;   end
      endcase
      sum = {1'b0, x} + {1'b0, y} + {4'b0, ~cn};
      case (s)
         4'h0: lf = ~a;
         4'h1: lf = ~(a | b);
         4'h2: lf = ~a & b;
         4'h3: lf = 4'h0;
         4'h4: lf = ~(a & b);
         4'h5: lf = ~b;
         4'h6: lf = a ^ b;
         4'h7: lf = a & ~b;
         4'h8: lf = ~a | b;
         4'h9: lf = ~(a ^ b);
         4'hA: lf = b;
         4'hB: lf = a & b;
         4'hC: lf = 4'hF;
         4'hD: lf = a | ~b;
         4'hE: lf = a | b;
         default: lf = a;
      endcase
      lf = m ? lf : sum[3:0];
      return {lf, ~sum[4], lf == 4'hF};
   endfunction
   always_comb {alu_f, alu_cn4, alu_aeqb} = slice(alu_a, alu_b, alu_s, alu_m, alu_cn);
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic run_op(input string tag, input logic [W-1:0] a, b, input fn_t fn,
                         input logic cn, input exp_t e, input int hold);
      exp_t got;
      int   n;
      q.push_back(e);
      @(negedge clk);
      check({tag, " req_ready idle"}, {31'b0, req_ready}, 1);
      req_valid = 1'b1; req_a = a; req_b = b; req_s = fn.s; req_m = fn.m; req_cn = cn;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_a = W'($urandom); req_b = W'($urandom); req_s = 4'($urandom); req_cn = ~cn;
      tr_s0 = alu_s; tr_m0 = alu_m;
      n = 0;
      while (!rsp_valid && n < 20) begin
         if (n < 8) begin
            tr_a[n] = alu_a; tr_b[n] = alu_b; tr_cn[n] = alu_cn;
         end
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " latency"}, n, N);
      got = q.pop_front();
      check({tag, " rsp_f"}, {16'b0, rsp_f}, {16'b0, got.f});
      check({tag, " rsp_cout"}, {31'b0, rsp_cout}, {31'b0, got.cout});
      check({tag, " rsp_aeqb"}, {31'b0, rsp_aeqb}, {31'b0, got.aeqb});
      check({tag, " rsp_zero"}, {31'b0, rsp_zero}, {31'b0, got.zero});
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_a = W'($urandom); req_b = W'($urandom); req_s = 4'($urandom);
         @(posedge clk);
         #1;
         check({tag, " hold rsp_valid"}, {31'b0, rsp_valid}, 1);
         check({tag, " hold rsp_f"}, {16'b0, rsp_f}, {16'b0, got.f});
         check({tag, " hold req_ready"}, {31'b0, req_ready}, 0);
         check({tag, " hold busy"}, {31'b0, busy}, 1);
         check({tag, " hold alu_a"}, {28'b0, alu_a}, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check({tag, " release rsp_valid"}, {31'b0, rsp_valid}, 0);
      check({tag, " release req_ready"}, {31'b0, req_ready}, 1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
   initial begin
      #2;
      check("reset req_ready", {31'b0, req_ready}, 1);
      check("reset busy", {31'b0, busy}, 0);
      check("reset rsp_valid", {31'b0, rsp_valid}, 0);
      check("reset rsp_f", {16'b0, rsp_f}, 0);
      check("reset alu", {19'b0, alu_a, alu_b, alu_s, alu_m}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("add1", 16'h1234, 16'h0FFF, FN_ADD, 1'b1, '{16'h2233, 1'b1, 1'b0, 1'b0}, 3);
      run_op("add2", 16'hFFFF, 16'h0001, FN_ADD, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1}, 0);
      check("add2 alu_cn ripple", {28'b0, tr_cn[0], tr_cn[1], tr_cn[2], tr_cn[3]}, 32'b1000);
      run_op("sub_eq", 16'h5678, 16'h5678, FN_SUB, 1'b1, '{16'hFFFF, 1'b1, 1'b1, 1'b0}, 0);
      run_op("sub_ne", 16'h5678, 16'h5679, FN_SUB, 1'b1, '{16'hFFFE, 1'b1, 1'b0, 1'b0}, 0);
      run_op("xor", 16'hF0F0, 16'hFF00, FN_XOR, 1'b1, '{16'h0FF0, 1'b1, 1'b0, 1'b0}, 1);
      check("xor alu_a seq", {16'b0, tr_a[0], tr_a[1], tr_a[2], tr_a[3]}, 32'h0F0F);
      check("xor alu_b seq", {16'b0, tr_b[0], tr_b[1], tr_b[2], tr_b[3]}, 32'h00FF);
      check("xor alu_s/m", {27'b0, tr_s0, tr_m0}, {27'b0, 4'b0110, 1'b1});
      run_op("and", 16'hF0F0, 16'hFF00, FN_AND, 1'b1, '{16'hF000, 1'b0, 1'b0, 1'b0}, 0);
      @(negedge clk);
      req_valid = 1'b1; req_a = 16'h1234; req_b = 16'h1111; req_s = FN_ADD.s; req_m = FN_ADD.m; req_cn = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("pre-reset busy", {31'b0, busy}, 1);
      rst_n = 1'b0;
      #1;
      check("midrun rsp_valid", {31'b0, rsp_valid}, 0);
      check("midrun busy", {31'b0, busy}, 0);
      check("midrun req_ready", {31'b0, req_ready}, 1);
      check("midrun alu", {19'b0, alu_a, alu_b, alu_s, alu_m}, 0);
      check("midrun alu_cn", {31'b0, alu_cn}, 0);
      check("midrun rsp_f", {16'b0, rsp_f}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_reset_add", 16'h0001, 16'h0001, FN_ADD, 1'b1, '{16'h0002, 1'b1, 1'b0, 1'b0}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
